// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: walks every pixel from start to end point inclusive
// and streams (x, y) on a valid/ready interface; one pixel per cycle when unstalled.
module line_rasterizer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [37:0] locations,
    output logic        busy,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state;
    logic [9:0]         x0, x1, cx;
    logic [8:0]         y0, y1, cy;
    logic signed [12:0] dx, dy, err;
    logic               sx, sy;

    logic signed [12:0] diff_x, diff_y, abs_x, abs_y, e2, err_next;
    logic               step_x, step_y, at_end, xfer;

    always_comb begin
        diff_x   = $signed({3'b000, x1}) - $signed({3'b000, x0});
        diff_y   = $signed({4'b0000, y1}) - $signed({4'b0000, y0});
        abs_x    = diff_x[12] ? -diff_x : diff_x;
        abs_y    = diff_y[12] ? -diff_y : diff_y;
        e2       = err <<< 1;
        step_x   = (e2 >= dy);
        step_y   = (e2 <= dx);
        // both steps are judged on the old err and fold into a single update
        err_next = err;
        if (step_x) err_next = err_next + dy;
        if (step_y) err_next = err_next + dx;
        at_end   = (cx == x1) && (cy == y1);
        xfer     = (state == ST_DRAW) && pix_ready;
    end

    assign busy      = (state != ST_IDLE);
    assign pix_valid = (state == ST_DRAW);
    assign done      = (state == ST_DONE);
    assign pix_x     = cx;
    assign pix_y     = cy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            x0    <= '0;
            y0    <= '0;
            x1    <= '0;
            y1    <= '0;
            cx    <= '0;
            cy    <= '0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
            sx    <= 1'b0;
            sy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x0    <= locations[37:28];
                        y0    <= locations[27:19];
                        x1    <= locations[18:9];
                        y1    <= locations[8:0];
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    dx    <= abs_x;
                    dy    <= -abs_y;
                    err   <= abs_x - abs_y;
                    sx    <= !diff_x[12] && (diff_x != 13'sd0);
                    sy    <= !diff_y[12] && (diff_y != 13'sd0);
                    cx    <= x0;
                    cy    <= y0;
                    state <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (xfer) begin
                        if (at_end) begin
                            state <= ST_DONE;
                        end else begin
                            err <= err_next;
                            if (step_x) cx <= sx ? cx + 10'd1 : cx - 10'd1;
                            if (step_y) cy <= sy ? cy + 9'd1 : cy - 9'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: hand-derived pixel sequences, timing and stall checks.
module tb_line_rasterizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [37:0] locations;
    logic        busy;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cap_x[$];
    int cap_y[$];
    int cap_c[$];
    int done_cyc;

    always #5 clk = ~clk;

    line_rasterizer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .locations (locations),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .done      (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issues one segment and captures every transfer; cycle 1 is the SETUP cycle.
    task automatic run_seg(input logic [9:0] ax0, input logic [8:0] ay0,
                           input logic [9:0] ax1, input logic [8:0] ay1,
                           input int stall_idx, input int stall_n, input bit inject);
        int cyc = 0;
        int stalled = 0;
        int hx = 0;
        int hy = 0;
        bit fin = 1'b0;
        cap_x.delete();
        cap_y.delete();
        cap_c.delete();
        done_cyc = -1;
        @(negedge clk);
        start     = 1'b1;
        locations = {ax0, ay0, ax1, ay1};
        pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("setup_busy", busy, 1);
        check("setup_valid", pix_valid, 0);
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                fin      = 1'b1;
                check("done_valid", pix_valid, 0);
                check("done_busy", busy, 1);
            end else if (pix_valid) begin
                if (cap_x.size() == stall_idx && stalled < stall_n) begin
                    if (stalled == 0) begin
                        hx = pix_x;
                        hy = pix_y;
                    end else begin
                        check("hold_x", pix_x, hx);
                        check("hold_y", pix_y, hy);
                    end
                    pix_ready = 1'b0;
                    stalled++;
                end else begin
                    pix_ready = 1'b1;
                    cap_x.push_back(int'(pix_x));
                    cap_y.push_back(int'(pix_y));
                    cap_c.push_back(cyc);
                    if (inject && cap_x.size() == 2) begin
                        start     = 1'b1;
                        locations = {10'd700, 9'd300, 10'd0, 9'd0};
                    end
                end
            end
        end
        check("timeout", fin, 1);
        pix_ready = 1'b1;
        @(negedge clk);
        check("after_busy", busy, 0);
        check("after_done", done, 0);
    endtask

    task automatic check_seq(input string tag, input int ex[4], input int ey[4]);
        check({tag, "_count"}, cap_x.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_x.size()) begin
                check($sformatf("%s_x%0d", tag, i), cap_x[i], ex[i]);
                check($sformatf("%s_y%0d", tag, i), cap_y[i], ey[i]);
            end
        end
    endtask

    initial begin
        int ex[4];
        int ey[4];
        int bad;
        int nv;
        int nd;
        reset     = 1'b1;
        start     = 1'b0;
        locations = '0;
        pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_x", pix_x, 0);
        check("rst_y", pix_y, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // single point: pixel at N+2, done at N+3, idle at N+4
        run_seg(10'd5, 9'd7, 10'd5, 9'd7, -1, 0, 1'b0);
        check("pt_count", cap_x.size(), 1);
        if (cap_x.size() == 1) begin
            check("pt_x", cap_x[0], 5);
            check("pt_y", cap_y[0], 7);
            check("pt_cyc", cap_c[0], 2);
        end
        check("pt_done_cyc", done_cyc, 3);

        // horizontal
        run_seg(10'd0, 9'd0, 10'd3, 9'd0, -1, 0, 1'b0);
        ex = '{0, 1, 2, 3}; ey = '{0, 0, 0, 0};
        check_seq("horiz", ex, ey);
        if (cap_c.size() == 4) begin
            check("horiz_first_cyc", cap_c[0], 2);
            check("horiz_last_cyc", cap_c[3], 5);
        end
        check("horiz_done_cyc", done_cyc, 6);

        // steep
        run_seg(10'd0, 9'd0, 10'd1, 9'd3, -1, 0, 1'b0);
        ex = '{0, 0, 1, 1}; ey = '{0, 1, 2, 3};
        check_seq("steep", ex, ey);

        // negative diagonal
        run_seg(10'd5, 9'd5, 10'd2, 9'd2, -1, 0, 1'b0);
        ex = '{5, 4, 3, 2}; ey = '{5, 4, 3, 2};
        check_seq("negdiag", ex, ey);

        // backpressure: 3 stalled cycles while (1,0) is presented
        run_seg(10'd0, 9'd0, 10'd3, 9'd0, 1, 3, 1'b0);
        ex = '{0, 1, 2, 3}; ey = '{0, 0, 0, 0};
        check_seq("stall", ex, ey);
        if (cap_c.size() == 4) check("stall_xfer1_cyc", cap_c[1], 6);
        check("stall_done_cyc", done_cyc, 9);

        // ignored start during DRAW
        run_seg(10'd0, 9'd0, 10'd3, 9'd0, -1, 0, 1'b1);
        ex = '{0, 1, 2, 3}; ey = '{0, 0, 0, 0};
        check_seq("ignstart", ex, ey);

        // extremes: x-major, every step moves x by -1 and y by 0 or +1
        run_seg(10'd1023, 9'd0, 10'd0, 9'd511, -1, 0, 1'b0);
        check("ext_count", cap_x.size(), 1024);
        if (cap_x.size() == 1024) begin
            check("ext_first_x", cap_x[0], 1023);
            check("ext_first_y", cap_y[0], 0);
            check("ext_last_x", cap_x[1023], 0);
            check("ext_last_y", cap_y[1023], 511);
            bad = 0;
            for (int i = 1; i < 1024; i++) begin
                if (cap_x[i] != cap_x[i-1] - 1) bad++;
                if (cap_y[i] != cap_y[i-1] && cap_y[i] != cap_y[i-1] + 1) bad++;
                if (cap_c[i] != cap_c[i-1] + 1) bad++;
            end
            check("ext_steps", bad, 0);
        end

        // reset mid-segment after the 2nd pixel
        @(negedge clk);
        start     = 1'b1;
        locations = {10'd0, 9'd0, 10'd9, 9'd0};
        pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        for (int i = 0; i < 20 && nv < 2; i++) begin
            @(negedge clk);
            if (pix_valid) nv++;
        end
        check("rst_mid_seen", nv, 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy", busy, 0);
        check("rstmid_valid", pix_valid, 0);
        check("rstmid_x", pix_x, 0);
        check("rstmid_y", pix_y, 0);
        check("rstmid_done", done, 0);
        nv = 0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (pix_valid) nv++;
            if (done) nd++;
        end
        check("rstmid_no_pix", nv, 0);
        check("rstmid_no_done", nd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
